pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register that replaces the fixed two-field stall-hold stage registers between pipeline stages.
- Carries an arbitrary-width payload with a valid/ready handshake on both sides.
- A 2-entry skid buffer keeps upstream ready registered, so backpressure never forms a combinational path across the stage.
- Adds synchronous flush (branch/trap squash) and saturating stall/bubble performance counters.

---
 rtl/pipe_stage_skid.sv | 131 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// It also has a synchronous flush and saturating stall/bubble counters.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W  = 128,
    parameter int unsigned       CNT_W   = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Bit 0 is main_valid and bit 1 is skid_valid. The 2'b10 pattern cannot be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid_in;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // in_ready comes straight from the state register, so downstream backpressure never reaches upstream combinationally.
    assign in_ready  = ~state[1];
    assign out_valid = state[0];
    assign out_data  = main_data;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt    = FULL;
                    load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_nxt    = SKID;
                    load_skid_in = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            SKID: begin
                if (out_fire) begin
                    state_nxt      = FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // A flush drops every held entry and leaves the payload registers untouched.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_skid_in   = 1'b0;
            load_main_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Payload registers load only on an accepted transfer or a skid-to-main move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= RST_VAL;
            skid_data <= RST_VAL;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid_in) begin
                skid_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (!out_valid && out_ready) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed vectors push the expected payloads into a queue,
// and a forked monitor pops and compares each payload as the DUT delivers it.
module tb_pipe_stage_skid;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic          cnt_clr;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;

    logic [DW-1:0] exp_q[$];
    int            n_vec;
    int            n_err;
    int            n_deliv;

    pipe_stage_skid #(
        .DATA_W (DW),
        .CNT_W  (CW),
        .RST_VAL(16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after each rising edge. Acceptance is sampled at the falling edge.
    task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy,
                        input logic fl, input logic clr);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
        @(negedge clk);
        if (iv && in_ready && !fl) exp_q.push_back(id);
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [DW-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL out_unexpected: got 0x%0h, expected no transfer", out_data);
                    end else begin
                        exp = exp_q.pop_front();
                        n_deliv++;
                        check("out_data_order", 32'(out_data), 32'(exp));
                    end
                end
                if (flush) exp_q.delete();
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_deliv = 0;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; cnt_clr = 1'b0;
        fork
            monitor();
        join_none

        // Reset state and idle bubbles
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_data", 32'(out_data), 32'h0);
        check("idle_bubble", 32'(bubble_cnt), 32'd3);
        check("idle_stall", 32'(stall_cnt), 32'd0);

        // Back-to-back stream at full throughput
        step(1'b1, 16'h11, 1'b1, 1'b0, 1'b0);
        check("stream_lat_valid", 32'(out_valid), 32'd1);
        check("stream_lat_data", 32'(out_data), 32'h11);
        check("stream_rdy0", 32'(in_ready), 32'd1);
        step(1'b1, 16'h22, 1'b1, 1'b0, 1'b0);
        check("stream_data1", 32'(out_data), 32'h22);
        check("stream_rdy1", 32'(in_ready), 32'd1);
        step(1'b1, 16'h33, 1'b1, 1'b0, 1'b0);
        check("stream_data2", 32'(out_data), 32'h33);
        check("stream_rdy2", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("stream_bubble", 32'(bubble_cnt), 32'd6);
        check("stream_stall", 32'(stall_cnt), 32'd0);

        // Backpressure fills the skid entry
        step(1'b1, 16'h000A, 1'b0, 1'b0, 1'b1);
        check("bp_clr_bubble", 32'(bubble_cnt), 32'd0);
        check("bp_rdy_full", 32'(in_ready), 32'd1);
        step(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        check("bp_rdy_skid", 32'(in_ready), 32'd0);
        check("bp_data_skid", 32'(out_data), 32'h000A);
        check("bp_stall1", 32'(stall_cnt), 32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("bp_stall3", 32'(stall_cnt), 32'd3);
        check("bp_rdy_hold", 32'(in_ready), 32'd0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("bp_rdy_back", 32'(in_ready), 32'd1);
        check("bp_data_b", 32'(out_data), 32'h000B);
        check("bp_stall_keep", 32'(stall_cnt), 32'd3);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("bp_empty_valid", 32'(out_valid), 32'd0);
        check("bp_empty_hold", 32'(out_data), 32'h000B);

        // Flush while in the SKID state
        step(1'b1, 16'h00C1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00C2, 1'b0, 1'b0, 1'b0);
        check("fl_rdy_skid", 32'(in_ready), 32'd0);
        step(1'b1, 16'h00C3, 1'b0, 1'b1, 1'b0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_rdy", 32'(in_ready), 32'd1);
        check("fl_data_hold", 32'(out_data), 32'h00C1);
        check("fl_stall", 32'(stall_cnt), 32'd5);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("fl_after_valid", 32'(out_valid), 32'd0);

        // Flush that coincides with an accepted input
        step(1'b1, 16'h00D1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00D2, 1'b0, 1'b1, 1'b0);
        check("fl2_valid", 32'(out_valid), 32'd0);
        check("fl2_data_hold", 32'(out_data), 32'h00D1);
        step(1'b1, 16'h00D3, 1'b1, 1'b0, 1'b0);
        check("fl2_next_data", 32'(out_data), 32'h00D3);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Counter saturation and clear
        step(1'b1, 16'h00E1, 1'b0, 1'b0, 1'b1);
        check("sat_clr", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("sat_stall_max", 32'(stall_cnt), 32'hF);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("sat_stall_hold", 32'(stall_cnt), 32'hF);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        check("sat_clr_prio", 32'(stall_cnt), 32'd0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("sat_restart", 32'(stall_cnt), 32'd1);
        check("sat_bubble", 32'(bubble_cnt), 32'd0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while the stage is FULL
        step(1'b1, 16'h0071, 1'b0, 1'b0, 1'b0);
        check("ar_pre_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_data", 32'(out_data), 32'h0);
        check("ar_rdy", 32'(in_ready), 32'd1);
        check("ar_stall", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 16'h0005, 1'b1, 1'b0, 1'b0);
        check("ar_fresh_data", 32'(out_data), 32'h0005);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        check("deliv_count", 32'(n_deliv), 32'd8);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
